// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: owns the pc, drives the
// instruction memory and hands words to decode.
module unidad_busqueda #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] leer_direccion,
  input  logic [31:0] instruccion_mem,
  input  logic        salto_tomado,
  input  logic [31:0] direccion_salto,
  input  logic        id_listo,
  output logic        if_valido,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic        error_alineacion,
  output logic        error_rango,
  output logic [31:0] contador_instr
);

  localparam logic [31:0] LIMITE = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    ARRANQUE,
    CORRIENDO,
    ERROR
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic        valido_q, valido_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        err_al_q, err_al_d;
  logic        err_rg_q, err_rg_d;
  logic [31:0] cnt_q, cnt_d;
  logic        libre;
  logic        transfer;

  assign libre    = !valido_q || id_listo;
  assign transfer = valido_q && id_listo;

  // Next-state: redirect beats range check beats fetch beats stall.
  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    valido_d = valido_q;
    instr_d  = instr_q;
    pc_id_d  = pc_id_q;
    err_al_d = err_al_q;
    err_rg_d = err_rg_q;
    cnt_d    = transfer ? cnt_q + 32'd1 : cnt_q;
    unique case (estado_q)
      ARRANQUE: begin
        estado_d = CORRIENDO;
      end
      CORRIENDO: begin
        if (salto_tomado && (direccion_salto[1:0] != 2'b00)) begin
          estado_d = ERROR;
          err_al_d = 1'b1;
          valido_d = 1'b0;
        end else if (salto_tomado) begin
          pc_d     = direccion_salto;
          valido_d = 1'b0;
        end else if ((pc_q >= LIMITE) && libre) begin
          estado_d = ERROR;
          err_rg_d = 1'b1;
          valido_d = 1'b0;
        end else if (libre) begin
          instr_d  = instruccion_mem;
          pc_id_d  = pc_q;
          valido_d = 1'b1;
          pc_d     = pc_q + 32'd4;
        end
      end
      ERROR: begin
        valido_d = 1'b0;
      end
      default: begin
        estado_d = ERROR;
        valido_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= ARRANQUE;
      pc_q     <= RESET_PC;
      valido_q <= 1'b0;
      instr_q  <= 32'h0;
      pc_id_q  <= 32'h0;
      err_al_q <= 1'b0;
      err_rg_q <= 1'b0;
      cnt_q    <= 32'h0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      valido_q <= valido_d;
      instr_q  <= instr_d;
      pc_id_q  <= pc_id_d;
      err_al_q <= err_al_d;
      err_rg_q <= err_rg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign leer_direccion   = pc_q;
  assign if_valido        = valido_q;
  assign instr_id         = instr_q;
  assign pc_id            = pc_id_q;
  assign error_alineacion = err_al_q;
  assign error_rango      = err_rg_q;
  assign contador_instr   = cnt_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Bench for unidad_busqueda: vector table, scoreboard
// of handed-off words, and corner-case sequences.
module tb_unidad_busqueda;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] leer_direccion;
  logic [31:0] instruccion_mem;
  logic        salto_tomado;
  logic [31:0] direccion_salto;
  logic        id_listo;
  logic        if_valido;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic        error_alineacion;
  logic        error_rango;
  logic [31:0] contador_instr;

  logic        r_reset;
  logic [31:0] r_dir;
  logic [31:0] r_mem;
  logic        r_salto;
  logic [31:0] r_dsalto;
  logic        r_listo;
  logic        r_valido;
  logic [31:0] r_instr;
  logic [31:0] r_pcid;
  logic        r_eal;
  logic        r_erg;
  logic [31:0] r_cnt;

  logic [31:0] mem [0:127];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        v;
    logic [31:0] pcid;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        listo;
    logic        salto;
    logic [31:0] dir;
  } vec_t;
  vec_t tbl [14];

  always #5 clk = ~clk;

  assign instruccion_mem = mem[leer_direccion[8:2]];
  assign r_mem           = mem[r_dir[8:2]];

  unidad_busqueda #(.RESET_PC(32'h0), .MEM_WORDS(128)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .leer_direccion   (leer_direccion),
    .instruccion_mem  (instruccion_mem),
    .salto_tomado     (salto_tomado),
    .direccion_salto  (direccion_salto),
    .id_listo         (id_listo),
    .if_valido        (if_valido),
    .instr_id         (instr_id),
    .pc_id            (pc_id),
    .error_alineacion (error_alineacion),
    .error_rango      (error_rango),
    .contador_instr   (contador_instr)
  );

  unidad_busqueda #(.RESET_PC(32'h0), .MEM_WORDS(4)) u_rng (
    .clk              (clk),
    .reset            (r_reset),
    .leer_direccion   (r_dir),
    .instruccion_mem  (r_mem),
    .salto_tomado     (r_salto),
    .direccion_salto  (r_dsalto),
    .id_listo         (r_listo),
    .if_valido        (r_valido),
    .instr_id         (r_instr),
    .pc_id            (r_pcid),
    .error_alineacion (r_eal),
    .error_rango      (r_erg),
    .contador_instr   (r_cnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    sb_t e;
    e.pc    = pc;
    e.instr = mem[pc[8:2]];
    sb.push_back(e);
  endtask

  // Compare every handed-off word against the scoreboard.
  always @(negedge clk) begin
    if (!reset && if_valido && id_listo) begin
      if (sb.size() == 0) begin
        chk("sb_extra_transfer", pc_id, 32'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_pc", pc_id, e.pc);
        chk("sb_instr", instr_id, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = 32'hA000_0000 | (i << 2);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;

    tbl[0]  = '{1'b0, 32'h00, 32'h00, 32'd0, 1'b1, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 32'h00, 32'h00, 32'd0, 1'b1, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 32'h00, 32'h04, 32'd0, 1'b1, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 32'h04, 32'h08, 32'd1, 1'b0, 1'b0, 32'h00};
    tbl[4]  = '{1'b1, 32'h04, 32'h08, 32'd1, 1'b0, 1'b0, 32'h00};
    tbl[5]  = '{1'b1, 32'h04, 32'h08, 32'd1, 1'b0, 1'b0, 32'h00};
    tbl[6]  = '{1'b1, 32'h04, 32'h08, 32'd1, 1'b1, 1'b0, 32'h00};
    tbl[7]  = '{1'b1, 32'h08, 32'h0C, 32'd2, 1'b1, 1'b0, 32'h00};
    tbl[8]  = '{1'b1, 32'h0C, 32'h10, 32'd3, 1'b0, 1'b1, 32'h20};
    tbl[9]  = '{1'b0, 32'h00, 32'h20, 32'd3, 1'b1, 1'b0, 32'h00};
    tbl[10] = '{1'b1, 32'h20, 32'h24, 32'd3, 1'b1, 1'b1, 32'h40};
    tbl[11] = '{1'b0, 32'h00, 32'h40, 32'd4, 1'b0, 1'b0, 32'h00};
    tbl[12] = '{1'b1, 32'h40, 32'h44, 32'd4, 1'b1, 1'b0, 32'h00};
    tbl[13] = '{1'b1, 32'h44, 32'h48, 32'd5, 1'b0, 1'b1, 32'h22};

    push(32'h00);
    push(32'h04);
    push(32'h08);
    push(32'h20);
    push(32'h40);

    reset = 1'b1; id_listo = 1'b0;
    salto_tomado = 1'b0; direccion_salto = 32'h0;
    r_reset = 1'b1; r_listo = 1'b1;
    r_salto = 1'b0; r_dsalto = 32'h0;
    step();
    step();
    chk("rst_instr_id", instr_id, 32'h0);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_err_rg", {31'b0, error_rango}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("t%0d_valid", i), {31'b0, if_valido}, {31'b0, tbl[i].v});
      chk($sformatf("t%0d_addr", i), leer_direccion, tbl[i].addr);
      chk($sformatf("t%0d_cnt", i), contador_instr, tbl[i].cnt);
      chk($sformatf("t%0d_eal", i), {31'b0, error_alineacion}, 32'h0);
      if (tbl[i].v)
        chk($sformatf("t%0d_pcid", i), pc_id, tbl[i].pcid);
      id_listo        = tbl[i].listo;
      salto_tomado    = tbl[i].salto;
      direccion_salto = tbl[i].dir;
      step();
    end

    chk("mis_eal", {31'b0, error_alineacion}, 32'h1);
    chk("mis_valid", {31'b0, if_valido}, 32'h0);
    chk("mis_addr", leer_direccion, 32'h48);
    chk("mis_cnt", contador_instr, 32'd5);
    chk("mis_erg", {31'b0, error_rango}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      id_listo = 1'b1;
      salto_tomado = 1'b1;
      direccion_salto = 32'h100;
      step();
      chk("err_addr_frozen", leer_direccion, 32'h48);
      chk("err_valid", {31'b0, if_valido}, 32'h0);
      chk("err_eal_sticky", {31'b0, error_alineacion}, 32'h1);
    end

    salto_tomado = 1'b0;
    id_listo = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_eal", {31'b0, error_alineacion}, 32'h0);
    chk("rst2_addr", leer_direccion, 32'h0);
    push(32'h00);
    push(32'h04);
    id_listo = 1'b1;
    step();
    chk("rst2_k1_valid", {31'b0, if_valido}, 32'h0);
    step();
    chk("rst2_k2_valid", {31'b0, if_valido}, 32'h1);
    chk("rst2_k2_pcid", pc_id, 32'h0);
    step();
    step();
    chk("mid_addr", leer_direccion, 32'h0C);
    chk("mid_valid", {31'b0, if_valido}, 32'h1);
    chk("mid_pcid", pc_id, 32'h08);
    reset = 1'b1;
    id_listo = 1'b0;
    step();
    chk("mid_rst_addr", leer_direccion, 32'h0);
    chk("mid_rst_valid", {31'b0, if_valido}, 32'h0);
    chk("mid_rst_instr", instr_id, 32'h0);
    chk("mid_rst_pcid", pc_id, 32'h0);
    chk("mid_rst_cnt", contador_instr, 32'h0);
    reset = 1'b0;
    step();
    chk("mid_k1_valid", {31'b0, if_valido}, 32'h0);
    step();
    chk("mid_k2_valid", {31'b0, if_valido}, 32'h1);
    chk("mid_k2_pcid", pc_id, 32'h0);
    chk("mid_k2_instr", instr_id, 32'h0050_0093);

    r_reset = 1'b0;
    step();
    chk("rng_k1_valid", {31'b0, r_valido}, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("rng_valid", {31'b0, r_valido}, 32'h1);
      chk("rng_pcid", r_pcid, 32'((k - 2) * 4));
      chk("rng_instr", r_instr, mem[k - 2]);
    end
    step();
    chk("rng_erg", {31'b0, r_erg}, 32'h1);
    chk("rng_valid_off", {31'b0, r_valido}, 32'h0);
    chk("rng_addr", r_dir, 32'h10);
    chk("rng_cnt", r_cnt, 32'd4);
    chk("rng_eal", {31'b0, r_eal}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rng_addr_frozen", r_dir, 32'h10);
      chk("rng_valid_hold", {31'b0, r_valido}, 32'h0);
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory read address. It captures the returned instruction word into an IF/ID output register and hands it to decode with a valid/ready handshake. It also accepts branch/jump redirects from execute, flushing the fetched slot, and latches alignment and range errors.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned (bits [1:0]=0).
MEM_WORDS, 128, instruction memory depth in 32-bit words; valid byte addresses are 0 .. MEM_WORDS*4-4.

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
leer_direccion  output  32  byte address to instruction memory; combinationally equal to pc
instruccion_mem  input  32  word returned by instruction memory; asynchronous read, valid in the same cycle
salto_tomado  input  1  redirect request from execute
direccion_salto  input  32  redirect target byte address
id_listo  input  1  decode can accept the current output
if_valido  output  1  instr_id/pc_id hold a valid fetched instruction
instr_id  output  32  fetched instruction (registered)
pc_id  output  32  byte address of instr_id (registered)
error_alineacion  output  1  sticky: misaligned redirect target seen
error_rango  output  1  sticky: pc left the memory range
contador_instr  output  32  count of instructions handed to decode

Behaviour:
- Reset (sampled at the clk edge while reset=1) sets:
  - pc=RESET_PC; if_valido=0; instr_id=0; pc_id=0.
  - error_alineacion=0; error_rango=0; contador_instr=0.
  - state=ARRANQUE.
  - Reset overrides every other input. Reset mid-stall or mid-redirect discards all pending state.
- FSM states: ARRANQUE, CORRIENDO, ERROR.
  - ARRANQUE: one cycle, no fetch, salto_tomado ignored. Always moves to CORRIENDO.
  - CORRIENDO: normal operation.
  - ERROR: terminal until reset. No fetch. pc is frozen. if_valido is cleared on the entry edge. Outputs other than if_valido hold.
- leer_direccion=pc at all times, including ERROR.
- Slot free condition: libre = !if_valido || id_listo.
- Handshake: transfer occurs on any edge with if_valido && id_listo. Each transfer increments contador_instr by 1, modulo 2^32 (wraps to 0).
- Priority in CORRIENDO, evaluated each edge, highest first:
  1. salto_tomado=1 with direccion_salto[1:0]!=0: enter ERROR, set error_alineacion=1, pc unchanged, if_valido=0.
  2. salto_tomado=1, aligned target:
     - pc=direccion_salto; if_valido=0 (flush).
     - Applies regardless of id_listo. A transfer on that same edge still counts.
     - No fetch this edge; the first fetch from the target happens on the next edge.
  3. pc >= MEM_WORDS*4 and libre: enter ERROR, set error_rango=1, if_valido=0.
  4. libre (fetch fires): instr_id=instruccion_mem; pc_id=pc; if_valido=1; pc=pc+4 (32-bit wrap).
  5. Otherwise (if_valido && !id_listo): stall. pc, instr_id, pc_id and if_valido hold bit-exact.
- Latency:
  - First valid output: the 2nd edge after reset deasserts (ARRANQUE edge, then the fetch edge).
  - Throughput: 1 instruction/cycle while id_listo=1.
  - Redirect penalty: one empty cycle (if_valido=0) before the target instruction is valid.
- While if_valido=0, id_listo is don't-care.
- Errors are never cleared except by reset.

Test Plan:
- Reset, then id_listo=1 held, memory words 0x00500093, 0x00A00113, 0x002081B3 at addresses 0/4/8 -> if_valido=0 for the first cycle. Then instr_id/pc_id = 0x00500093/0, 0x00A00113/4, 0x002081B3/8 on consecutive cycles. contador_instr=3 after the third transfer.
- Stall: id_listo=0 for 3 cycles while pc_id=4 -> instr_id, pc_id and leer_direccion=8 stay constant. On release, pc_id=8 appears the next cycle and contador_instr increments once per release transfer.
- Redirect during stall: if_valido=1, id_listo=0, salto_tomado=1, direccion_salto=0x20 -> next cycle if_valido=0, leer_direccion=0x20. The following cycle pc_id=0x20 with instr_id=mem[8].
- Misaligned redirect to 0x22 -> error_alineacion=1, if_valido=0, leer_direccion frozen. It stays frozen for 10 cycles and is cleared only by reset.
- Range with MEM_WORDS=4: sequential fetch 0..0xC -> at pc=0x10, error_rango=1, if_valido=0, and no further pc change.
- Reset asserted mid-stream at pc=0x0C with if_valido=1 -> next edge: pc=RESET_PC, all outputs 0. Then the normal ARRANQUE-then-fetch sequence resumes.
